// File: rtl/arbiter_rr_n.sv
// N-requester round-robin arbiter with registered one-hot grant, grant
// locking while the holder keeps requesting, optional maximum hold time and
// an encoded grant index.
module arbiter_rr_n #(
  parameter  int unsigned N        = 3,
  parameter  int unsigned MAX_HOLD = 0,
  localparam int unsigned ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  // Hold counter only needs to reach MAX_HOLD-1; it saturates beyond that.
  localparam int unsigned CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0]     grant_n;
  logic             grant_valid_n;
  logic [ID_W-1:0]  grant_id_n;
  logic [ID_W-1:0]  ptr_n;
  logic [CNT_W-1:0] cnt_n;

  logic             found;
  logic [ID_W-1:0]  win;
  int unsigned      pos;
  logic             hold_ok;
  logic             hold;

  // Circular search for the first requester after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[ID_W'(pos)]) begin
        found = 1'b1;
        win   = ID_W'(pos);
      end
    end
  end

  // Next-state: keep the holder while allowed, otherwise reselect.
  always_comb begin
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_id_n    = grant_id;
    ptr_n         = ptr;
    cnt_n         = cnt;

    hold_ok = (MAX_HOLD == 0) || (32'(cnt) < HOLD_LIM);
    hold    = grant_valid && req[grant_id] && hold_ok;

    if (hold) begin
      if (cnt != {CNT_W{1'b1}}) cnt_n = cnt + CNT_W'(1);
    end else if (found) begin
      grant_n       = {{(N-1){1'b0}}, 1'b1} << win;
      grant_valid_n = 1'b1;
      grant_id_n    = win;
      ptr_n         = win;
      cnt_n         = '0;
    end else begin
      grant_n       = '0;
      grant_valid_n = 1'b0;
      grant_id_n    = '0;
    end
  end

  // State and output registers; reset points the search at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= ID_W'(N - 1);
      cnt         <= '0;
    end else begin
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
    end
  end

endmodule

// File: doc/arbiter_rr_n.md
Name: arbiter_rr_n

Overview:
N-requester round-robin arbiter with registered (Moore) one-hot grant. It is the parametrised successor of the fixed 3-input priority arbiter. It adds rotating fairness, grant locking while the holder keeps requesting, an optional maximum hold time, an encoded grant index, and asynchronous reset. It sits between N request sources and a shared resource; consumers decode grant or grant_id directly.

Parameters:
N, 3, number of requesters (legal range 2..32)
MAX_HOLD, 0, maximum consecutive cycles one requester may hold the grant while others wait; 0 means unlimited (lock until release)
ID_W, $clog2(N), width of grant_id (localparam, derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  N  request vector, bit i = requester i; level-sensitive
grant  output  N  registered one-hot grant, all-zero when idle
grant_valid  output  1  registered, high when any grant bit is set (equals |grant)
grant_id  output  ID_W  registered binary index of the granted requester; 0 when idle

Behaviour:
- Reset (async assert, clk-synchronous deassert by the environment): grant=0, grant_valid=0, grant_id=0, last pointer ptr=N-1, hold count cnt=0. After reset, requester 0 has highest priority.
- All outputs come straight from flops. No combinational path from req to outputs.
- Latency: req sampled at rising edge t produces grant after edge t (visible in cycle t+1). One cycle from request to grant, and one cycle from release to regrant.
- Next-state rule, evaluated every edge. Let g be the current holder.
  - HOLD: grant_valid=1, req[g]=1, and (MAX_HOLD==0 or cnt<MAX_HOLD-1). Keep g; cnt<=cnt+1, saturating.
  - SELECT: any other case. Circular search of req starting at index ptr+1 mod N; the first set bit w wins. Then grant<=onehot(w), grant_id<=w, ptr<=w, cnt<=0. If req==0: grant<=0, grant_id<=0, grant_valid<=0; ptr and cnt are unchanged.
- ptr updates only on SELECT with a winner. It always equals the most recent winner, so the search after a release or expiry starts just after the previous holder.
- Expiry with no competitors: the circular search from g+1 wraps back to g. g is re-granted, grant stays high without a gap, and cnt restarts at 0.
- Release and new request on the same edge: a holder dropping req while others request hands over in the same edge. There is no idle cycle.
- Simultaneous requests from idle: the winner is the first set bit after ptr, wrapping at N-1 to 0.
- Requests appearing mid-hold do not pre-empt the holder before release or expiry.
- Reset mid-grant: outputs clear immediately (asynchronously) and ptr returns to N-1.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid == |grant.
  - grant_id == index of the set grant bit.
  - A granted requester always has req high at the sampling edge.
- X on req is not tolerated. The bench must drive known values after reset.

Test Plan:
(All with N=3, MAX_HOLD=4 unless stated.)
- Reset/idle: assert rst mid-cycle with grant=3'b010. grant=000, grant_id=0, grant_valid=0 immediately. With req=000 after release, grant stays 000.
- Simultaneous start: after reset, req=111 at edge 1. grant=001, id=0 after edge 1. Holder 0 keeps grant for 4 cycles, then grant=010 (id=1), then 4 cycles later 100 (id=2), then 001. This rotation repeats.
- Early release: req=011, holder 0. Drop req[0] at edge 3 with req[1]=1. grant=010 after edge 3, with no idle cycle between.
- Lone holder expiry: only req[2]=1 for 10 cycles. grant=100 continuously with no gap. The internal cnt restart is checked via assertion that the output never drops.
- Unlimited lock (MAX_HOLD=0): req=111 for 20 cycles. grant stays 001. Drop req[0]: grant=010 next edge.
- Wrap and pointer: last winner 2, idle 5 cycles, then req=101. grant=001. Last winner 0, then req=101 again after an idle cycle: grant=100.
